// File: rtl/mesi_mem_responder.sv
// Shared backing-store responder for N MESI cache controllers: round-robin
// grant, fixed LAT-cycle access, one-cycle mem_ack pulse to the served cache.
module mesi_mem_responder #(
  parameter int N      = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int LAT    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      mem_read,
  input  logic [N-1:0]      mem_write,
  input  logic [31:0]       addr  [N],
  input  logic [DATA_W-1:0] wdata [N],
  output logic [N-1:0]      mem_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int AW  = $clog2(DEPTH);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;

  // Handshake: a cache holds mem_read/mem_write (level) until it sees its
  // mem_ack bit for one cycle, then drops the request the following cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    id_q;
  logic              op_wr_q;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [N-1:0]      req;
  logic              gnt_found;
  logic [IDW-1:0]    gnt_id;
  int                j;

  assign req       = mem_read | mem_write;
  assign state_dbg = state;

  // Walk offsets from the far end down so the requester closest to rr_ptr wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    j         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      id_q    <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      mem_ack <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_ack <= '0;
          if (gnt_found) begin
            id_q    <= gnt_id;
            op_wr_q <= mem_write[gnt_id];
            idx_q   <= addr[gnt_id][AW+1:2];
            wdata_q <= wdata[gnt_id];
            cnt     <= CW'(LAT - 1);
            busy    <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            mem_ack       <= '0;
            mem_ack[id_q] <= 1'b1;
            if (!op_wr_q) rdata <= mem[idx_q];
            state <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (op_wr_q) mem[idx_q] <= wdata_q;
          mem_ack <= '0;
          busy    <= 1'b0;
          rr_ptr  <= (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_ack <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_mem_responder.sv
// Directed bench for mesi_mem_responder (N=2, DATA_W=32, DEPTH=16, LAT=3)
// with hand-computed expected values checked by immediate assertions.
module tb_mesi_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_read;
  logic [1:0]  mem_write;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  mem_ack;
  logic [31:0] rdata;
  logic        busy;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  mesi_mem_responder #(.N(2), .DATA_W(32), .DEPTH(16), .LAT(3)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .mem_ack(mem_ack), .rdata(rdata),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs driven 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for any mem_ack and checks which bit pulsed and the latency.
  task automatic wait_ack(input string tag, input logic [1:0] exp_mask, input int exp_n);
    int n = 0;
    do begin
      tick();
      n++;
    end while (mem_ack == 2'b00 && n < 20);
    check({tag, "_lat"}, 64'(n), 64'(exp_n));
    check({tag, "_ack"}, 64'(mem_ack), 64'(exp_mask));
    check({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic drive(input int c, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    mem_read[c]  = rd;
    mem_write[c] = wr;
    addr[c]      = a;
    wdata[c]     = d;
  endtask

  task automatic drop_all();
    mem_read  = 2'b00;
    mem_write = 2'b00;
  endtask

  // One isolated transaction from cache c; rdata is checked in the ack cycle.
  task automatic txn(input string tag, input int c, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
    drive(c, rd, wr, a, d);
    wait_ack(tag, 2'(1 << c), 4);
    check({tag, "_rdata"}, 64'(rdata), 64'(exp_rd));
    drop_all();
    tick();
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    drop_all();
    for (int i = 0; i < 2; i++) begin
      addr[i]  = '0;
      wdata[i] = '0;
    end
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ack", 64'(mem_ack), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);

    // Write then read back, back-to-back transactions.
    txn("wr08", 0, 1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 32'h0);
    txn("rd08", 0, 1'b1, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF);

    // Contention with both requests held: 0, then 1, then 0 again.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h08, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h08, 32'h0);
    wait_ack("cont_a", 2'b01, 4);
    wait_ack("cont_b", 2'b10, 5);
    wait_ack("cont_c", 2'b01, 5);
    check("cont_rdata", 64'(rdata), 64'd0);
    drop_all();
    tick();

    // Read and write asserted together resolve to a write; rdata holds.
    txn("rw04", 1, 1'b1, 1'b1, 32'h04, 32'h55, 32'h0);
    txn("rd04", 0, 1'b1, 1'b0, 32'h04, 32'h0, 32'h55);

    // Reset during ACCESS aborts the write.
    drive(0, 1'b0, 1'b1, 32'h0C, 32'hA5);
    tick();
    tick();
    check("abort_busy_pre", 64'(busy), 64'd1);
    check("abort_state_pre", 64'(state_dbg), 64'd1);
    rst = 1'b1;
    drop_all();
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ack", 64'(mem_ack), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_noack", 64'(mem_ack), 64'd0);
    end
    txn("rd0c", 0, 1'b1, 1'b0, 32'h0C, 32'h0, 32'h0);

    // Address aliasing modulo DEPTH words.
    txn("wr40", 1, 1'b0, 1'b1, 32'h40, 32'h11, 32'h0);
    txn("rd00", 0, 1'b1, 1'b0, 32'h00, 32'h0, 32'h11);

    // Inputs change and the request drops during ACCESS; transaction unaffected.
    drive(0, 1'b0, 1'b1, 32'h14, 32'h77);
    tick();
    drive(0, 1'b0, 1'b0, 32'h18, 32'h99);
    wait_ack("latch", 2'b01, 3);
    check("latch_rdata", 64'(rdata), 64'h11);
    drop_all();
    tick();
    txn("rd14", 1, 1'b1, 1'b0, 32'h14, 32'h0, 32'h77);
    txn("rd18", 1, 1'b1, 1'b0, 32'h18, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mesi_mem_responder.md
MESI_MEM_RESPONDER -- requirements
Module: mesi_mem_responder

Interface
REQ-001 The block SHALL have parameter N, default 2, the number of cache controllers served.
REQ-002 The block SHALL have parameter DATA_W, default 32, the data word width.
REQ-003 The block SHALL have parameter DEPTH, default 16, the backing-store size in words (power of two, >=2).
REQ-004 The block SHALL have parameter LAT, default 3, the access latency in cycles (>=1).
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port clk, input, 1 bit: the clock.
REQ-007 The block SHALL have port rst, input, 1 bit: the synchronous active-high reset.
REQ-008 The block SHALL have port mem_read, input, N bits: per-cache read request, level, held until acked.
REQ-009 The block SHALL have port mem_write, input, N bits: per-cache write request, level, held until acked.
REQ-010 The block SHALL have port addr, input, 32 bits x N (unpacked [N]): the per-cache byte address.
REQ-011 The block SHALL have port wdata, input, DATA_W bits x N (unpacked [N]): the per-cache write data.
REQ-012 The block SHALL have port mem_ack, output, N bits: a one-cycle completion pulse to the serviced cache.
REQ-013 The block SHALL have port rdata, output, DATA_W bits: read data, valid in the mem_ack cycle of a read.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, ACCESS and RESP.
REQ-016 IDLE: when any bit of (mem_read | mem_write) is 1, the block SHALL grant one requester, latch its id, op, word index and wdata, load the counter with LAT-1, and go to ACCESS.
REQ-017 The grant SHALL be round-robin: search from rr_ptr upward, modulo N; the first requester found wins.
REQ-018 The word index SHALL be addr[log2(DEPTH)+1:2]; upper address bits are ignored, so addresses alias modulo DEPTH words.
REQ-019 If the granted cache asserts both mem_read and mem_write, the op SHALL be a write.
REQ-020 ACCESS: the counter SHALL decrement each cycle; when it reads 0, the FSM SHALL go to RESP, so ACCESS lasts exactly LAT cycles.
REQ-021 RESP: for one cycle, mem_ack[id] SHALL be 1 and all other mem_ack bits 0.
REQ-022 RESP, read: rdata SHALL equal mem[index].
REQ-023 RESP, write: mem[index] SHALL take the latched wdata at the end of the cycle, and rdata SHALL hold its previous value.
REQ-024 RESP: rr_ptr SHALL take (id+1) mod N, and the FSM SHALL return to IDLE.
REQ-025 A request seen in IDLE at cycle t SHALL be acked at cycle t+LAT+1; busy SHALL be high from t+1 through t+LAT+1.
REQ-026 Requests arriving while busy SHALL be ignored until the next IDLE cycle and SHALL NOT be lost if they are held.
REQ-027 Inputs SHALL be latched at grant; deasserting a request or changing addr/wdata during ACCESS SHALL NOT affect the transaction in flight.
REQ-028 The requester SHALL drop its request in the cycle after mem_ack; a request still high in the following IDLE cycle SHALL be treated as a new request.
REQ-029 A read of an index written by the immediately preceding transaction SHALL return the new data.
REQ-030 mem_ack, rdata and busy SHALL be registered outputs.

Reset
REQ-031 When rst=1 at a clock edge, the block SHALL set the state to IDLE, rr_ptr to 0, the counter to 0, mem_ack to 0, rdata to 0, busy to 0, and all DEPTH words to 0.
REQ-032 A reset during ACCESS or RESP SHALL abort the transaction: no memory update and no mem_ack.
REQ-033 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-034 Write then read: cache0 writes addr 0x08 with data 0xDEADBEEF, then reads addr 0x08 -> mem_ack[0] pulses at t+4 for each transaction (LAT=3), and the read gives rdata=0xDEADBEEF.
REQ-035 Contention: after reset, cache0 and cache1 raise mem_read in the same cycle and hold it -> cache0 is served first and cache1 next; on a repeated collision cache1 wins because rr_ptr=1.
REQ-036 Read+write collision: cache1 asserts both requests for addr 0x04 with wdata 0x55 -> a write; a later read of 0x04 returns 0x55.
REQ-037 Reset mid-access: cache0 writes 0xA5 to 0x0C and rst is pulsed during ACCESS -> no mem_ack, busy=0; a later read of 0x0C returns 0.
REQ-038 Alias and latching: write 0x11 to addr 0x40 (DEPTH=16), then read addr 0x00 -> rdata=0x11; changing addr during ACCESS has no effect on the transaction in flight.
